// File: rtl/iot_sensor_pkg.sv
// Shared types and constants for the IoT sensor pipeline.
// The framer's timestamp option is selected by the FRAMER_TIMESTAMP_EN macro.
package iot_sensor_pkg;

  // Sensor IDs as they come out of the arbiter
  localparam logic [1:0] SENSOR_TEMPERATURE = 2'd0;
  localparam logic [1:0] SENSOR_HUMIDITY    = 2'd1;
  localparam logic [1:0] SENSOR_MOTION      = 2'd2;

  // Packet length without the timestamp option, and with it
  localparam int PKT_LEN_BASE = 5;
  localparam int PKT_LEN_TS   = 7;

  // Framer byte states; TSH/TSL are only reachable with timestamps enabled
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    IDB,
    DHI,
    DLO,
    TSH,
    TSL,
    CHK
  } framer_state_t;

  // Second packet byte: sequence number in the top nibble, sensor ID at the bottom
  function automatic logic [7:0] id_seq_byte(input logic [3:0] seq, input logic [1:0] id);
    return {seq, 2'b00, id};
  endfunction

endpackage

// File: rtl/framer_checksum.sv
// Running packet checksum (byte-wise XOR).
// Kept behind a clear/update/value interface so a CRC can replace it without
// touching the framer FSM.
module framer_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       update,
  input  logic [7:0] din,
  output logic [7:0] value
);

  logic [7:0] acc;

  // Clear restarts the sum; a simultaneous update seeds it with the first byte
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 8'h00;
    end else if (clear) begin
      acc <= update ? din : 8'h00;
    end else if (update) begin
      acc <= acc ^ din;
    end
  end

  assign value = acc;

endmodule

// File: rtl/sensor_packet_framer.sv
// Wraps arbitrated 16-bit sensor samples into byte packets:
//   SYNC, {seq,2'b00,id}, data[15:8], data[7:0], [ts[15:8], ts[7:0]], checksum
// Define FRAMER_TIMESTAMP_EN to add the two timestamp bytes (7-byte packets).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends on registered state and enable only. tx_valid, once
// raised, stays high until the checksum byte transfers, and tx_data/tx_last
// hold steady while the byte is stalled.
module sensor_packet_framer
  import iot_sensor_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_id,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic [15:0] pkt_count
);

  framer_state_t state, state_next;

  logic [15:0] data_hold;
  logic [1:0]  id_hold;
  logic [3:0]  seq;

  logic        accept;
  logic        advance;
  logic        load;
  logic        done;
  logic [7:0]  byte_next;
  logic        valid_next;
  logic        last_next;
  logic [7:0]  chk_value;

`ifdef FRAMER_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  logic [15:0] ts_hold;

  // Free-running cycle counter, wraps naturally at 16'hFFFF
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= 16'h0000;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
    end
  end
`endif

  assign in_ready = (state == IDLE) && enable;
  assign accept   = in_valid && in_ready;
  assign advance  = tx_valid && tx_ready;
  assign busy     = (state != IDLE);

  // Next state and the next byte to present; load marks bytes fed to the checksum
  always_comb begin
    state_next = state;
    byte_next  = tx_data;
    valid_next = tx_valid;
    last_next  = tx_last;
    load       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = HDR;
          byte_next  = SYNC_BYTE;
          valid_next = 1'b1;
          last_next  = 1'b0;
          load       = 1'b1;
        end
      end
      HDR: begin
        if (advance) begin
          state_next = IDB;
          byte_next  = id_seq_byte(seq, id_hold);
          load       = 1'b1;
        end
      end
      IDB: begin
        if (advance) begin
          state_next = DHI;
          byte_next  = data_hold[15:8];
          load       = 1'b1;
        end
      end
      DHI: begin
        if (advance) begin
          state_next = DLO;
          byte_next  = data_hold[7:0];
          load       = 1'b1;
        end
      end
`ifdef FRAMER_TIMESTAMP_EN
      DLO: begin
        if (advance) begin
          state_next = TSH;
          byte_next  = ts_hold[15:8];
          load       = 1'b1;
        end
      end
      TSH: begin
        if (advance) begin
          state_next = TSL;
          byte_next  = ts_hold[7:0];
          load       = 1'b1;
        end
      end
      TSL: begin
        if (advance) begin
          state_next = CHK;
          byte_next  = chk_value;
          last_next  = 1'b1;
        end
      end
`else
      DLO: begin
        if (advance) begin
          state_next = CHK;
          byte_next  = chk_value;
          last_next  = 1'b1;
        end
      end
`endif
      CHK: begin
        if (advance) begin
          state_next = IDLE;
          valid_next = 1'b0;
          last_next  = 1'b0;
          done       = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered byte stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      tx_data  <= byte_next;
      tx_valid <= valid_next;
      tx_last  <= last_next;
    end
  end

  // Sample capture on accept; sequence and packet counters on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      data_hold <= 16'h0000;
      id_hold   <= 2'd0;
      seq       <= 4'd0;
      pkt_count <= 16'h0000;
`ifdef FRAMER_TIMESTAMP_EN
      ts_hold   <= 16'h0000;
`endif
    end else begin
      if (accept) begin
        data_hold <= in_data;
        id_hold   <= in_id;
`ifdef FRAMER_TIMESTAMP_EN
        ts_hold   <= ts_cnt;
`endif
      end
      if (done) begin
        seq <= seq + 4'd1;
        if (pkt_count != 16'hFFFF) begin
          pkt_count <= pkt_count + 16'd1;
        end
      end
    end
  end

  framer_checksum u_checksum (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .update (load),
    .din    (byte_next),
    .value  (chk_value)
  );

endmodule

// File: tb/tb_sensor_packet_framer.sv
// Self-checking bench for sensor_packet_framer (FRAMER_TIMESTAMP_EN selects
// the 7-byte timestamped packet format here as well).
module tb_sensor_packet_framer;
  import iot_sensor_pkg::*;

`ifdef FRAMER_TIMESTAMP_EN
  localparam int PLEN = PKT_LEN_TS;
`else
  localparam int PLEN = PKT_LEN_BASE;
`endif

  // clock / reset / DUT
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] in_data;
  logic [1:0]  in_id;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  sensor_packet_framer dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_data   (in_data),
    .in_id     (in_id),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_last   (tx_last),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic        exp_last_q[$];
  logic [55:0] pkt_log[$];
  logic [55:0] cur_pkt = '0;
  logic [7:0]  pk[$];
  logic        m_busy = 1'b0;
  logic [3:0]  m_seq = 4'd0;
  logic [15:0] m_cnt = 16'd0;
  logic        armed = 1'b0;
  logic [7:0]  xsum;
  int          rdy_mode = 0;
  int          rdy_phase = 0;

`ifdef FRAMER_TIMESTAMP_EN
  logic [15:0] ref_cyc = 16'd0;
  always @(posedge clk) begin
    if (rst) ref_cyc <= 16'd0;
    else     ref_cyc <= ref_cyc + 16'd1;
  end
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] b1_of(input logic [55:0] p);
    return p[(PLEN-2)*8 +: 8];
  endfunction

  // tx_ready driver: 0 = always ready, 1 = random, 2 = pattern 1,0,0 repeating
  always @(posedge clk) begin
    #1;
    rdy_phase = rdy_phase + 1;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = (rdy_phase % 3 == 0);
    endcase
  end

  // Monitor + reference model: compares state before this edge, then applies
  // the transfers that will happen at the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      armed = 1'b1;
      exp_q.delete();
      exp_last_q.delete();
      pkt_log.delete();
      cur_pkt = '0;
      m_busy = 1'b0;
      m_seq = 4'd0;
      m_cnt = 16'd0;
    end else if (armed) begin
      check("in_ready", 64'(in_ready), 64'(!m_busy && enable));
      check("busy", 64'(busy), 64'(m_busy));
      check("tx_valid", 64'(tx_valid), 64'(m_busy));
      check("pkt_count", 64'(pkt_count), 64'(m_cnt));
      if (tx_valid) begin
        if (exp_q.size() == 0) begin
          check("tx_unexpected", 64'(tx_data), 64'hDEAD);
        end else begin
          check("tx_data", 64'(tx_data), 64'(exp_q[0]));
          check("tx_last", 64'(tx_last), 64'(exp_last_q[0]));
        end
      end
      if (tx_valid && tx_ready && exp_q.size() > 0) begin
        cur_pkt = {cur_pkt[47:0], tx_data};
        void'(exp_q.pop_front());
        if (exp_last_q.pop_front()) begin
          pkt_log.push_back(cur_pkt);
          cur_pkt = '0;
          m_busy = 1'b0;
          m_seq = m_seq + 4'd1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      if (in_valid && in_ready) begin
        pk.delete();
        pk.push_back(8'hA5);
        pk.push_back({m_seq, 2'b00, in_id});
        pk.push_back(in_data[15:8]);
        pk.push_back(in_data[7:0]);
`ifdef FRAMER_TIMESTAMP_EN
        pk.push_back(ref_cyc[15:8]);
        pk.push_back(ref_cyc[7:0]);
`endif
        xsum = 8'h00;
        foreach (pk[i]) xsum = xsum ^ pk[i];
        pk.push_back(xsum);
        foreach (pk[i]) begin
          exp_q.push_back(pk[i]);
          exp_last_q.push_back(i == pk.size() - 1);
        end
        m_busy = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] id, input logic [15:0] d);
    bit ok = 1'b0;
    in_id = id;
    in_data = d;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (!m_busy && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] cnt0;

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_id = '0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tx_data", 64'(tx_data), 64'h0);
    check("rst_tx_valid", 64'(tx_valid), 64'h0);
    check("rst_tx_last", 64'(tx_last), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_pkt_count", 64'(pkt_count), 64'h0);
    @(posedge clk);
    #1;

    // single motion packet, always ready
    rdy_mode = 0;
    send(SENSOR_MOTION, 16'h9ABC);
    wait_idle();
    check("t1_count", 64'(pkt_count), 64'd1);
    check("t1_logged", 64'(pkt_log.size()), 64'd1);
`ifndef FRAMER_TIMESTAMP_EN
    check("t1_bytes", 64'(pkt_log[0][39:0]), 64'hA5029ABC81);
`endif

    // seventeen temperature packets: sequence wrap
    do_reset();
    for (int i = 0; i < 17; i++) send(SENSOR_TEMPERATURE, 16'h1234);
    wait_idle();
    check("t2_count", 64'(pkt_count), 64'd17);
    check("t2_logged", 64'(pkt_log.size()), 64'd17);
`ifndef FRAMER_TIMESTAMP_EN
    check("t2_pkt0", 64'(pkt_log[0][39:0]), 64'hA500123483);
    check("t2_pkt1", 64'(pkt_log[1][39:0]), 64'hA510123493);
`endif
    check("t2_pkt15_b1", 64'(b1_of(pkt_log[15])), 64'hF0);
    check("t2_pkt16_b1", 64'(b1_of(pkt_log[16])), 64'h00);

    // backpressure 1,0,0 pattern
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) send(2'($urandom_range(0, 2)), 16'($urandom));
    wait_idle();
    check("t3_count", 64'(pkt_count), 64'd23);

    // random backpressure and gaps
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      send(2'($urandom_range(0, 2)), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    check("t4_count", 64'(pkt_count), 64'd43);

    // enable gating
    rdy_mode = 0;
    cnt0 = pkt_count;
    enable = 1'b0;
    in_id = SENSOR_HUMIDITY;
    in_data = 16'h5A5A;
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t5_gated_busy", 64'(busy), 64'd0);
    check("t5_gated_count", 64'(pkt_count), 64'(cnt0));
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("t5_in_dhi", 64'(tx_data), 64'h5A);
    enable = 1'b0;
    wait_idle();
    check("t5_completed", 64'(pkt_count), 64'(cnt0 + 16'd1));
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t5_no_more", 64'(pkt_count), 64'(cnt0 + 16'd1));
    check("t5_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    enable = 1'b1;

    // reset in the middle of a packet
    send(SENSOR_HUMIDITY, 16'hBEEF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("t6_in_dhi", 64'(tx_data), 64'hBE);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t6_tx_valid", 64'(tx_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_count", 64'(pkt_count), 64'd0);
    send(SENSOR_MOTION, 16'h0F0F);
    wait_idle();
    check("t6_logged", 64'(pkt_log.size()), 64'd1);
    check("t6_seq0", 64'(b1_of(pkt_log[0])), 64'h02);
    check("t6_count_after", 64'(pkt_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
